// File: rtl/matrix_calc_pkg.sv
// rtl/matrix_calc_pkg.sv - shared types and constants for the matrix calculator entry path
// Contents: op_t (opcode decoder output), entry_state_t (entry sequencer states),
//           KEY_DIGIT_MAX (largest raw key code treated as a digit).
package matrix_calc_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'b00,
      OP_ADD   = 2'b01,
      OP_SUB   = 2'b10,
      OP_ENTER = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      LOAD_A     = 3'd0,
      WAIT_OP    = 3'd1,
      LOAD_B     = 3'd2,
      WAIT_ENTER = 3'd3,
      EXEC       = 3'd4,
      RESULT     = 3'd5
   } entry_state_t;

   localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/key_event_sync.sv
// rtl/key_event_sync.sv - 2-flop synchronizer and rising-edge detector for the keypad strobe
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   key_strobe            asynchronous level from the keypad scanner
//   key_in, is_op, op_in  key fields, stable while key_strobe is high
//   ev                    single-cycle key event on the synchronized rising edge
//   ev_key, ev_is_op, ev_op  key fields presented together with ev
module key_event_sync
   import matrix_calc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_strobe,
   input  logic [3:0] key_in,
   input  logic       is_op,
   input  logic [1:0] op_in,
   output logic       ev,
   output logic [3:0] ev_key,
   output logic       ev_is_op,
   output op_t        ev_op
);

   logic [2:0] sync_q, sync_d;
   logic [3:0] key_q, key_d;
   logic       is_op_q, is_op_d;
   logic [1:0] op_q, op_d;

   // Key fields are re-captured every cycle; the scanner holds them stable for
   // the whole strobe, so the copy seen alongside the edge is settled.
   always_comb begin
      sync_d  = {sync_q[1:0], key_strobe};
      key_d   = key_in;
      is_op_d = is_op;
      op_d    = op_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         key_q   <= '0;
         is_op_q <= 1'b0;
         op_q    <= '0;
      end else begin
         sync_q  <= sync_d;
         key_q   <= key_d;
         is_op_q <= is_op_d;
         op_q    <= op_d;
      end
   end

   // sync_q[1] is the second synchronizer stage; sync_q[2] its previous value.
   assign ev       = sync_q[1] & ~sync_q[2];
   assign ev_key   = key_q;
   assign ev_is_op = is_op_q;
   assign ev_op    = op_t'(op_q);

endmodule

// File: rtl/matrix_entry_ctrl.sv
// rtl/matrix_entry_ctrl.sv - keypad entry sequencer for the matrix calculator
// Optional feature macro: MATRIX_KEY_SYNC_EN (asynchronous level strobe, synchronized,
//   3-cycle latency); undefined: key_strobe is a synchronous 1-cycle pulse, 1-cycle latency.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   key_strobe, key_in         key event and raw key code
//   is_op, op_in               opcode decoder outputs
//   wr_en, wr_sel, wr_addr, wr_data   operand write port (sel 0 = A, 1 = B)
//   alu_op, alu_start, alu_done       matrix ALU control
//   busy                       high while the ALU runs
//   err                        1-cycle pulse on a rejected key
//   state_o                    current state for debug/display
module matrix_entry_ctrl
   import matrix_calc_pkg::*;
#(
   parameter int DIM = 2,
   parameter int DW  = 4,
   parameter int AW  = $clog2(DIM*DIM)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_strobe,
   input  logic [3:0]    key_in,
   input  logic          is_op,
   input  logic [1:0]    op_in,
   output logic          wr_en,
   output logic          wr_sel,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic [1:0]    alu_op,
   output logic          alu_start,
   input  logic          alu_done,
   output logic          busy,
   output logic          err,
   output logic [2:0]    state_o
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DIM*DIM-1);

   logic       ev;
   logic [3:0] ev_key;
   logic       ev_is_op;
   op_t        ev_op;

`ifdef MATRIX_KEY_SYNC_EN
   key_event_sync u_key_event_sync (
      .clk        (clk),
      .rst        (rst),
      .key_strobe (key_strobe),
      .key_in     (key_in),
      .is_op      (is_op),
      .op_in      (op_in),
      .ev         (ev),
      .ev_key     (ev_key),
      .ev_is_op   (ev_is_op),
      .ev_op      (ev_op)
   );
`else
   assign ev       = key_strobe;
   assign ev_key   = key_in;
   assign ev_is_op = is_op;
   assign ev_op    = op_t'(op_in);
`endif

   entry_state_t  state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          wr_en_q, wr_en_d;
   logic          wr_sel_q, wr_sel_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic [1:0]    alu_op_q, alu_op_d;
   logic          alu_start_q, alu_start_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;

   logic k_digit, k_op, k_bad;

   always_comb begin
      k_digit = ev && !ev_is_op && (ev_key <= KEY_DIGIT_MAX);
      k_op    = ev && ev_is_op;
      k_bad   = ev && !ev_is_op && (ev_key > KEY_DIGIT_MAX);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_en_d     = 1'b0;
      wr_sel_d    = wr_sel_q;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      alu_op_d    = alu_op_q;
      alu_start_d = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         LOAD_A, LOAD_B: begin
            if (k_digit) begin
               wr_en_d   = 1'b1;
               wr_sel_d  = (state_q == LOAD_B);
               wr_addr_d = cnt_q;
               wr_data_d = DW'(ev_key);
               if (cnt_q == LAST_ADDR) begin
                  cnt_d   = '0;
                  state_d = (state_q == LOAD_A) ? WAIT_OP : WAIT_ENTER;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (k_op && ev_op == OP_NOP) begin
               // NOP clears A in place, and in LOAD_B cancels the whole entry.
               cnt_d   = '0;
               state_d = LOAD_A;
            end else if (k_op || k_bad) begin
               err_d = 1'b1;
            end
         end
         WAIT_OP: begin
            if (k_op && (ev_op == OP_ADD || ev_op == OP_SUB)) begin
               alu_op_d = ev_op;
               state_d  = LOAD_B;
            end else if (k_op && ev_op == OP_NOP) begin
               cnt_d   = '0;
               state_d = LOAD_A;
            end else if (k_digit || k_op || k_bad) begin
               err_d = 1'b1;
            end
         end
         WAIT_ENTER: begin
            if (k_op && ev_op == OP_ENTER) begin
               alu_start_d = 1'b1;
               state_d     = EXEC;
            end else if (k_op && ev_op == OP_NOP) begin
               cnt_d   = '0;
               state_d = LOAD_A;
            end else if (k_digit || k_op || k_bad) begin
               err_d = 1'b1;
            end
         end
         EXEC: begin
            // Keys are dropped silently while the ALU runs.
            if (alu_done) begin
               state_d = RESULT;
            end
         end
         RESULT: begin
            // Any valid key acknowledges the result; a digit here is not stored.
            if (k_digit || k_op) begin
               cnt_d   = '0;
               state_d = LOAD_A;
            end else if (k_bad) begin
               err_d = 1'b1;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = LOAD_A;
         end
      endcase

      busy_d = (state_d == EXEC);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= LOAD_A;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_sel_q    <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         alu_op_q    <= '0;
         alu_start_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         wr_sel_q    <= wr_sel_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         alu_op_q    <= alu_op_d;
         alu_start_q <= alu_start_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_sel    = wr_sel_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign alu_op    = alu_op_q;
   assign alu_start = alu_start_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// tb/tb_matrix_entry_ctrl.sv - self-checking bench for matrix_entry_ctrl (default build)
module tb_matrix_entry_ctrl;

   localparam int DIM = 2;
   localparam int DW  = 4;
   localparam int AW  = 2;
   localparam int N   = DIM*DIM;

   logic          clk = 1'b0;
   logic          rst;
   logic          key_strobe;
   logic [3:0]    key_in;
   logic          is_op;
   logic [1:0]    op_in;
   logic          wr_en;
   logic          wr_sel;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [1:0]    alu_op;
   logic          alu_start;
   logic          alu_done;
   logic          busy;
   logic          err;
   logic [2:0]    state_o;

   always #5 clk = ~clk;

   matrix_entry_ctrl #(.DIM(DIM), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_strobe (key_strobe),
      .key_in     (key_in),
      .is_op      (is_op),
      .op_in      (op_in),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .alu_done   (alu_done),
      .busy       (busy),
      .err        (err),
      .state_o    (state_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0..5 = A entry, await op, B entry, await enter, computing, result shown.
   int m_phase, m_cnt, m_aluop;
   int e_wr, e_sel, e_addr, e_data, e_start, e_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_cnt = 0; m_aluop = 0;
      e_wr = 0; e_sel = 0; e_addr = 0; e_data = 0; e_start = 0; e_err = 0;
   endtask

   task automatic model_step(input bit s, input int k, input bit iop, input int op, input bit done);
      bit dig, bad, opk;
      int prev;
      e_wr = 0; e_start = 0; e_err = 0;
      dig  = s && !iop && k <= 9;
      bad  = s && !iop && k > 9;
      opk  = s && iop;
      prev = m_phase;
      if (prev == 0 || prev == 2) begin
         if (dig) begin
            e_wr = 1; e_sel = prev / 2; e_addr = m_cnt; e_data = k;
            m_cnt = m_cnt + 1;
            if (m_cnt == N) begin m_cnt = 0; m_phase = prev + 1; end
         end else if (opk && op == 0) begin
            m_cnt = 0; m_phase = 0;
         end else if (opk || bad) e_err = 1;
      end else if (prev == 1) begin
         if (opk && (op == 1 || op == 2)) begin m_aluop = op; m_phase = 2; end
         else if (opk && op == 0) begin m_cnt = 0; m_phase = 0; end
         else if (dig || opk || bad) e_err = 1;
      end else if (prev == 3) begin
         if (opk && op == 3) begin e_start = 1; m_phase = 4; end
         else if (opk && op == 0) begin m_cnt = 0; m_phase = 0; end
         else if (dig || opk || bad) e_err = 1;
      end else if (prev == 4) begin
         if (done) m_phase = 5;
      end else begin
         if (dig || opk) begin m_cnt = 0; m_phase = 0; end
         else if (bad) e_err = 1;
      end
   endtask

   task automatic check_all();
      chk("wr_en", wr_en, e_wr);
      if (e_wr != 0) begin
         chk("wr_sel", wr_sel, e_sel);
         chk("wr_addr", wr_addr, e_addr);
         chk("wr_data", wr_data, e_data);
      end
      chk("alu_start", alu_start, e_start);
      chk("err", err, e_err);
      chk("busy", busy, (m_phase == 4) ? 1 : 0);
      chk("state_o", state_o, m_phase);
      chk("alu_op", alu_op, m_aluop);
   endtask

   task automatic cyc(input bit s, input logic [3:0] k, input bit iop, input logic [1:0] op, input bit done);
      key_strobe = s; key_in = k; is_op = iop; op_in = op; alu_done = done;
      model_step(s, int'(k), iop, int'(op), done);
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      key_strobe = 1'b0; alu_done = 1'b0;
   endtask

   task automatic digit(input logic [3:0] k);
      cyc(1'b1, k, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic opkey(input logic [1:0] op, input logic [3:0] code);
      cyc(1'b1, code, 1'b1, op, 1'b0);
   endtask

   task automatic idle(input bit done);
      cyc(1'b0, 4'd0, 1'b0, 2'b00, done);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_en"}, wr_en, 0);
      chk({tag, "_wr_sel"}, wr_sel, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_alu_op"}, alu_op, 0);
      chk({tag, "_alu_start"}, alu_start, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_state"}, state_o, 0);
   endtask

   initial begin
      rst = 1'b0; key_strobe = 1'b0; key_in = '0; is_op = 1'b0; op_in = '0; alu_done = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;

      // A entry 1..4
      for (int i = 1; i <= 4; i++) digit(4'(i));
      chk("a_full_state", state_o, 1);

      // rejected keys in WAIT_OP
      digit(4'd7);
      opkey(2'b11, 4'b1101);
      chk("wait_op_hold", state_o, 1);

      // SUB, B entry 5..8, ENTER, run
      opkey(2'b10, 4'b1100);
      chk("alu_op_sub", alu_op, 2);
      for (int i = 5; i <= 8; i++) digit(4'(i));
      chk("b_full_state", state_o, 3);
      opkey(2'b11, 4'b1101);
      chk("start_pulse", alu_start, 1);
      idle(1'b0);
      chk("start_one_cycle", alu_start, 0);
      digit(4'd9);
      chk("exec_key_no_err", err, 0);
      idle(1'b0);
      idle(1'b1);
      chk("result_state", state_o, 5);
      digit(4'd3);
      chk("result_no_write", wr_en, 0);

      // cancel in the middle of B
      for (int i = 1; i <= 4; i++) digit(4'(i));
      opkey(2'b01, 4'b1010);
      digit(4'd2);
      digit(4'd3);
      opkey(2'b00, 4'b1010);
      chk("nop_cancel_state", state_o, 0);
      digit(4'd6);
      chk("after_cancel_sel", wr_sel, 0);
      chk("after_cancel_addr", wr_addr, 0);

      // invalid key leaves the counter alone
      cyc(1'b1, 4'b1111, 1'b0, 2'b00, 1'b0);
      chk("invalid_err", err, 1);
      digit(4'd7);
      chk("invalid_cnt_kept", wr_addr, 1);
      digit(4'd8);
      digit(4'd9);

      // get into EXEC, then reset between edges
      opkey(2'b01, 4'b1010);
      for (int i = 0; i < 4; i++) digit(4'(i));
      opkey(2'b11, 4'b1101);
      idle(1'b0);
      chk("exec_busy", busy, 1);
      #2 rst = 1'b0;
      #1 chk_all_zero("async_rst");
      model_reset();
      @(negedge clk);
      rst = 1'b1;

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         int cls;
         bit s, dn;
         logic [3:0] k;
         logic [1:0] op;
         s   = ($urandom_range(0, 1) == 1);
         cls = $urandom_range(0, 99);
         op  = 2'($urandom_range(0, 3));
         if (m_phase == 4) dn = ($urandom_range(0, 2) == 0);
         else              dn = ($urandom_range(0, 9) == 0);
         if (cls < 50) begin
            k = 4'($urandom_range(0, 9));
            cyc(s, k, 1'b0, op, dn);
         end else if (cls < 85) begin
            k = 4'($urandom_range(0, 15));
            cyc(s, k, 1'b1, op, dn);
         end else begin
            k = 4'($urandom_range(10, 15));
            cyc(s, k, 1'b0, op, dn);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
